// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time PWM gate driver.
package pwm_pkg;

    localparam int DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        DT_TO_HS = 3'd1,
        HS_ON    = 3'd2,
        DT_TO_LS = 3'd3,
        LS_ON    = 3'd4
    } dt_state_e;

endpackage

// File: rtl/dt_counter.sv
// Loadable dead-time down counter; saturates at zero instead of wrapping.
module dt_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         cnt_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary gate driver: inserts dead time between high/low-side drive,
// with enable gating and a sticky fault latch.
module pwm_deadtime_driver
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            hs_out,
    output logic            ls_out,
    output logic            fault_latched
);

    dt_state_e       state, next_state;
    logic            pwm_q;
    logic            load;
    logic [DT_W-1:0] load_val;
    logic            cnt_zero;

    // Counter holds (cycles - 1), so dead_time of 0 or 1 both give one cycle.
    assign load_val = (dead_time == '0) ? '0 : dead_time - DT_W'(1);

    dt_counter #(.W(DT_W)) u_dt_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .cnt_zero (cnt_zero)
    );

    always_comb begin
        next_state = state;
        if (fault || !en) begin
            next_state = OFF;
        end else begin
            case (state)
                OFF:      if (!fault_latched) next_state = pwm_q ? DT_TO_HS : DT_TO_LS;
                LS_ON:    if (pwm_q)          next_state = DT_TO_HS;
                HS_ON:    if (!pwm_q)         next_state = DT_TO_LS;
                // A command reversal inside the gap falls back to the side still safe to drive.
                DT_TO_HS: if (!pwm_q)         next_state = LS_ON;
                          else if (cnt_zero)  next_state = HS_ON;
                DT_TO_LS: if (pwm_q)          next_state = HS_ON;
                          else if (cnt_zero)  next_state = LS_ON;
                default:                      next_state = OFF;
            endcase
        end
        load = (next_state != state) &&
               ((next_state == DT_TO_HS) || (next_state == DT_TO_LS));
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= OFF;
            pwm_q         <= 1'b0;
            hs_out        <= 1'b0;
            ls_out        <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state  <= next_state;
            pwm_q  <= pwm_in;
            hs_out <= (next_state == HS_ON);
            ls_out <= (next_state == LS_ON);
            if (fault)
                fault_latched <= 1'b1;
            else if (fault_clr)
                fault_latched <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed bench for the dead-time driver plus a randomized overlap sweep.
module tb_pwm_deadtime_driver;

    logic       clk = 1'b0;
    logic       rst, en, pwm_in, fault, fault_clr;
    logic [7:0] dead_time;
    logic       hs_out, ls_out, fault_latched;
    int         errors = 0;
    int         checks = 0;

    pwm_deadtime_driver #(.DT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .hs_out        (hs_out),
        .ls_out        (ls_out),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_hs, input logic exp_ls);
        check({tag, ".hs"}, hs_out, exp_hs);
        check({tag, ".ls"}, ls_out, exp_ls);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm_in = 1'b0; dead_time = 8'd4;
        fault = 1'b0; fault_clr = 1'b0;
        step();
        step();
        check_out("reset", 1'b0, 1'b0);
        check("reset.fl", fault_latched, 1'b0);

        // Startup from OFF with pwm low: 4-cycle gap, then low side on.
        rst = 1'b0; en = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            check_out($sformatf("start%0d", j), 1'b0, 1'b0);
        end
        step();
        check_out("start5", 1'b0, 1'b1);

        // dead_time=4, 20-cycle period: hs for j%20 in 5..10, ls for 15..19,0.
        pwm_in = 1'b1;
        for (int j = 0; j < 40; j++) begin
            int m;
            step();
            m = j % 20;
            check_out($sformatf("per%0d", j), (m >= 5 && m <= 10), (m == 0 || m >= 15));
            pwm_in = (((j + 1) % 20) < 10);
        end
        pwm_in = 1'b0;

        // dead_time=0 behaves as a single-cycle gap.
        dead_time = 8'd0;
        pwm_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            check_out($sformatf("dt0_%0d", j), (j >= 2 && j <= 5), (j == 0 || j >= 7));
            pwm_in = ((j + 1) < 5);
        end

        // 3-cycle pulse against 10-cycle dead time is swallowed.
        dead_time = 8'd10;
        pwm_in = 1'b1;
        for (int j = 0; j < 15; j++) begin
            step();
            check_out($sformatf("swallow%0d", j), 1'b0, (j == 0 || j >= 4));
            pwm_in = ((j + 1) < 3);
        end

        // dead_time changed mid-gap must not shorten the current gap.
        dead_time = 8'd3;
        pwm_in = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step();
            check_out($sformatf("dtchg%0d", j), (j >= 4), (j == 0));
            if (j == 2) dead_time = 8'd0;
        end

        // Fault during HS_ON, clear blocked while fault high, restart via DT state.
        dead_time = 8'd2;
        fault = 1'b1;
        step();
        check_out("fault", 1'b0, 1'b0);
        check("fault.fl", fault_latched, 1'b1);
        fault = 1'b0;
        step();
        check("fault.hold", fault_latched, 1'b1);
        fault = 1'b1; fault_clr = 1'b1;
        step();
        check("clr_blocked", fault_latched, 1'b1);
        fault = 1'b0; fault_clr = 1'b0;
        step();
        check("clr_blocked2", fault_latched, 1'b1);
        fault_clr = 1'b1;
        step();
        check("clr", fault_latched, 1'b0);
        check_out("clr", 1'b0, 1'b0);
        fault_clr = 1'b0;
        step();
        check_out("restart1", 1'b0, 1'b0);
        step();
        check_out("restart2", 1'b0, 1'b0);
        step();
        check_out("restart3", 1'b1, 1'b0);

        // en dropped inside DT_TO_HS, then reset mid-pulse.
        pwm_in = 1'b0;
        repeat (4) step();
        check_out("low", 1'b0, 1'b1);
        pwm_in = 1'b1;
        step();
        step();
        check_out("dt_hs", 1'b0, 1'b0);
        en = 1'b0;
        step();
        check_out("en_off", 1'b0, 1'b0);
        step();
        check_out("en_off2", 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_out("en_on1", 1'b0, 1'b0);
        step();
        check_out("en_on2", 1'b0, 1'b0);
        step();
        check_out("en_on3", 1'b1, 1'b0);
        rst = 1'b1; fault = 1'b1;
        step();
        check_out("rst_mid", 1'b0, 1'b0);
        check("rst_prio.fl", fault_latched, 1'b0);
        rst = 1'b0; fault = 1'b0;

        // Random sweep: gate drives never overlap.
        for (int j = 0; j < 10000; j++) begin
            rst       = ($urandom_range(199) == 0);
            en        = ($urandom_range(19) != 0);
            if ($urandom_range(5) == 0) pwm_in = ~pwm_in;
            fault     = ($urandom_range(149) == 0);
            fault_clr = ($urandom_range(9) == 0);
            dead_time = 8'($urandom_range(5));
            step();
            check($sformatf("overlap%0d", j), hs_out & ls_out, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_driver.md
PWM_DEADTIME_DRIVER -- requirements
Module: pwm_deadtime_driver

Interface
REQ-001 The block SHALL have parameter DT_W, default 8, giving the dead-time count width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port en  input  1  driver enable; low forces both outputs off.
REQ-005 The block SHALL have port pwm_in  input  1  PWM command from the upstream shadow PWM generator, same clock domain.
REQ-006 The block SHALL have port dead_time  input  DT_W  dead-time length in clk cycles, unsigned.
REQ-007 The block SHALL have port fault  input  1  external fault, active-high, level.
REQ-008 The block SHALL have port fault_clr  input  1  single-cycle request to clear a latched fault.
REQ-009 The block SHALL have port hs_out  output  1  high-side gate drive, registered.
REQ-010 The block SHALL have port ls_out  output  1  low-side gate drive, registered.
REQ-011 The block SHALL have port fault_latched  output  1  sticky fault status, registered.

Function
REQ-012 pwm_in SHALL be registered once (pwm_q); all decisions SHALL use pwm_q.
REQ-013 FSM states SHALL be: OFF, DT_TO_HS, HS_ON, DT_TO_LS, LS_ON.
REQ-014 OFF: both outputs 0; if en=1 and fault_latched=0, SHALL go to DT_TO_HS if pwm_q=1, else DT_TO_LS.
REQ-015 LS_ON: ls_out=1; pwm_q=1 SHALL go to DT_TO_HS.
REQ-016 HS_ON: hs_out=1; pwm_q=0 SHALL go to DT_TO_LS.
REQ-017 DT_TO_HS/DT_TO_LS: both outputs 0 for exactly max(dead_time,1) cycles, then HS_ON/LS_ON respectively.
REQ-018 dead_time SHALL be sampled on entry to a DT state; changes mid-interval SHALL NOT affect the current interval.
REQ-019 If pwm_q reverses during DT_TO_HS, the FSM SHALL return to LS_ON next cycle (and symmetrically DT_TO_LS returns to HS_ON); pulses shorter than the dead time are thus swallowed.
REQ-020 Latency: pwm_in sampled high at edge k SHALL make ls_out 0 after edge k+1 and hs_out 1 after edge k+1+max(dead_time,1); falling direction symmetric.
REQ-021 hs_out and ls_out SHALL never both be 1 in any cycle, including across reset, enable and fault transitions.
REQ-022 en=0 sampled in any state SHALL go to OFF with both outputs 0 after the next edge.
REQ-023 fault=1 sampled SHALL set fault_latched and force OFF with both outputs 0 after that edge; fault has priority over en and pwm_q.
REQ-024 fault_clr SHALL clear fault_latched only when fault=0 in the same cycle; with fault=1 simultaneously, the latch SHALL remain set.
REQ-025 After a fault is cleared, restart SHALL go through OFF and a full DT state; no direct entry to HS_ON or LS_ON.
REQ-026 The dead-time counter SHALL be DT_W bits, load-and-decrement, and SHALL never wrap below 0.

Reset
REQ-027 rst=1 sampled SHALL put the FSM in OFF and drive hs_out=0, ls_out=0, fault_latched=0, pwm_q=0, counter=0.
REQ-028 Reset mid-dead-time or mid-pulse SHALL take effect after the same edge, with no output glitch high.
REQ-029 rst SHALL have priority over fault, en and fault_clr.

Structure
REQ-030 Package pwm_pkg SHALL hold the state enum dt_state_e and the default DT_W constant.
REQ-031 The loadable down counter SHALL be one sub-module, dt_counter (ports clk, rst, load, load_val, cnt_zero).

Verification
REQ-032 dead_time=4, en=1, pwm_in toggles with a 20-cycle period -> both outputs 0 for exactly 4 cycles at each transition; hs_out high for 6 cycles per period.
REQ-033 dead_time=0 -> both outputs 0 for exactly 1 cycle at each edge.
REQ-034 dead_time=10, pwm_in high pulse of 3 cycles during LS_ON -> hs_out stays 0; ls_out returns to 1 with no overlap.
REQ-035 fault pulsed 1 cycle during HS_ON -> hs_out 0 after next edge; fault_latched=1; fault_clr with fault=1 ignored; fault_clr with fault=0 -> restart via DT state.
REQ-036 en dropped during DT_TO_HS, then rst asserted mid-pulse -> outputs 0 after the next edge; overlap assertion (hs_out & ls_out) never fires over 10k random cycles.
